// File: rtl/friscv_pkg.sv
// Core-wide constants shared by the friscv pipeline stages.
// Latency: n/a (constants only).
// Backpressure: n/a.
package friscv_pkg;
    localparam int XLEN       = 32;
    localparam int XLEN_BYTES = XLEN / 8;
endpackage

// File: rtl/if_stage.sv
// Instruction fetch: samples the PC, runs one req/gnt/rvalid fetch, loads IF/ID.
// Latency: 3 cycles minimum per instruction (IDLE, REQ, WAIT); pc_advance_out pulses in the load cycle.
// Backpressure: stall_in holds IF/ID and parks the returned word in a hold buffer; flush_in drops it.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   pc_in                    current PC from the pc block
//   stall_in, flush_in       hazard-unit controls (flush wins over stall)
//   pc_advance_out           instruction accepted into IF/ID, PC may update at this edge
//   imem_req/addr/gnt/rvalid/rdata   instruction-memory request/grant/response interface
//   if_id_valid/instr/pc/pc_nxt_out IF/ID pipeline register
//   fetch_err_out            sticky fetch watchdog error
//
// Optional feature: define FETCH_TIMEOUT_EN to enable the fetch watchdog;
// otherwise fetch_err_out is tied 0.
module if_stage
    import friscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    input  logic            stall_in,
    input  logic            flush_in,
    output logic            pc_advance_out,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_gnt_in,
    input  logic            imem_rvalid_in,
    input  logic [31:0]     imem_rdata_in,
    output logic            if_id_valid_out,
    output logic [31:0]     if_id_instr_out,
    output logic [XLEN-1:0] if_id_pc_out,
    output logic [XLEN-1:0] if_id_pc_nxt_out,
    output logic            fetch_err_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] addr_q;
    logic [31:0]     hold_q;
    logic            valid_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_nxt_q;

    logic load_wait;   // response goes straight into IF/ID
    logic load_hold;   // parked response goes into IF/ID after a stall
    logic park;        // response captured into the hold buffer

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        load_wait = 1'b0;
        load_hold = 1'b0;
        park      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // The request stays up even when flushed; its response is
                // simply thrown away later.
                if (flush_in)    discard_d = 1'b1;
                if (imem_gnt_in) state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid_in) begin
                    state_d = S_IDLE;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else if (flush_in) begin
                        state_d = S_IDLE;
                    end else if (stall_in) begin
                        park    = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        load_wait = 1'b1;
                    end
                end else if (flush_in) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush_in) begin
                    state_d = S_IDLE;
                end else if (!stall_in) begin
                    load_hold = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pc_advance_out = load_wait | load_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
            addr_q    <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            pc_nxt_q  <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (state_q == S_IDLE) addr_q <= pc_in;
            if (park)              hold_q <= imem_rdata_in;

            if (flush_in) begin
                valid_q <= 1'b0;
                instr_q <= NOP_INSTR;
            end else if (stall_in) begin
                valid_q <= valid_q;
            end else if (pc_advance_out) begin
                valid_q  <= 1'b1;
                instr_q  <= load_hold ? hold_q : imem_rdata_in;
                pc_q     <= addr_q;
                pc_nxt_q <= addr_q + XLEN'(XLEN_BYTES);
            end else begin
                // Bubble between fetches.
                valid_q <= 1'b0;
            end
        end
    end

    assign imem_req_out     = (state_q == S_REQ);
    assign imem_addr_out    = addr_q;
    assign if_id_valid_out  = valid_q;
    assign if_id_instr_out  = instr_q;
    assign if_id_pc_out     = pc_q;
    assign if_id_pc_nxt_out = pc_nxt_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             err_q;

    // Saturating increment so a hung fetch never wraps back below the limit.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                cnt_q <= '0;
            end else if (state_q == S_REQ || state_q == S_WAIT) begin
                cnt_q <= cnt_inc;
                if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) err_q <= 1'b1;
            end
        end
    end

    assign fetch_err_out = err_q;
`else
    // No watchdog: the comparison is false for every legal limit.
    assign fetch_err_out = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import friscv_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_in = '0;
    logic        stall_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        pc_advance_out;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in = 1'b0;
    logic        imem_rvalid_in = 1'b0;
    logic [31:0] imem_rdata_in = '0;
    logic        if_id_valid_out;
    logic [31:0] if_id_instr_out;
    logic [31:0] if_id_pc_out;
    logic [31:0] if_id_pc_nxt_out;
    logic        fetch_err_out;

    int n_checks = 0;
    int n_pass   = 0;

    if_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_in            (pc_in),
        .stall_in         (stall_in),
        .flush_in         (flush_in),
        .pc_advance_out   (pc_advance_out),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .imem_gnt_in      (imem_gnt_in),
        .imem_rvalid_in   (imem_rvalid_in),
        .imem_rdata_in    (imem_rdata_in),
        .if_id_valid_out  (if_id_valid_out),
        .if_id_instr_out  (if_id_instr_out),
        .if_id_pc_out     (if_id_pc_out),
        .if_id_pc_nxt_out (if_id_pc_nxt_out),
        .fetch_err_out    (fetch_err_out)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, outputs are sampled at posedge+5 (negedge).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        stall_in = 1'b0; flush_in = 1'b0;
        imem_gnt_in = 1'b0; imem_rvalid_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;   // this cycle is the first IDLE cycle
    endtask

    // Drives one complete fetch from an IDLE cycle and records what the
    // memory side and pc_advance_out looked like. Transaction model: 1 IDLE
    // cycle, gnt_dly+1 REQ cycles, rv_dly+1 WAIT cycles, then stall_len-1
    // HOLD cycles plus a release cycle when a stall meets the response.
    task automatic do_fetch(input logic [31:0] pc, input int gnt_dly, input int rv_dly,
                            input logic [31:0] data, input int stall_len,
                            output int req_cyc, output int adv_cnt, output bit addr_ok,
                            output bit adv_in_load, output bit held_ok);
        logic [31:0] s_instr, s_pc, s_nxt;
        logic        s_valid;
        s_instr = '0; s_pc = '0; s_nxt = '0; s_valid = 1'b0;
        req_cyc = 0; adv_cnt = 0; addr_ok = 1'b1; adv_in_load = 1'b0; held_ok = 1'b1;
        pc_in = pc; imem_gnt_in = 1'b0; imem_rvalid_in = 1'b0;
        stall_in = 1'b0; flush_in = 1'b0; imem_rdata_in = $urandom;
        #4;
        if (imem_req_out) req_cyc++;
        if (pc_advance_out) adv_cnt++;
        tick();
        pc_in = $urandom;
        for (int i = 0; i <= gnt_dly; i++) begin
            imem_gnt_in = (i == gnt_dly);
            imem_rvalid_in = 1'($urandom_range(0, 1));   // must be ignored in REQ
            imem_rdata_in = $urandom;
            #4;
            if (imem_req_out) req_cyc++;
            if (imem_addr_out !== pc) addr_ok = 1'b0;
            if (pc_advance_out) adv_cnt++;
            tick();
        end
        imem_gnt_in = 1'b0;
        for (int j = 0; j <= rv_dly; j++) begin
            imem_rvalid_in = (j == rv_dly);
            imem_rdata_in = imem_rvalid_in ? data : $urandom;
            stall_in = (stall_len > 0) && (j == rv_dly);
            if (stall_in) begin
                s_valid = if_id_valid_out; s_instr = if_id_instr_out;
                s_pc = if_id_pc_out; s_nxt = if_id_pc_nxt_out;
            end
            #4;
            if (imem_req_out) req_cyc++;
            if (pc_advance_out) begin
                adv_cnt++;
                if (imem_rvalid_in && stall_len == 0) adv_in_load = 1'b1;
            end
            tick();
        end
        imem_rvalid_in = 1'b0; imem_rdata_in = $urandom;
        if (stall_len > 0) begin
            for (int k = 1; k < stall_len; k++) begin
                stall_in = 1'b1;
                if ({if_id_valid_out, if_id_instr_out, if_id_pc_out, if_id_pc_nxt_out} !==
                    {s_valid, s_instr, s_pc, s_nxt}) held_ok = 1'b0;
                #4;
                if (imem_req_out) req_cyc++;
                if (pc_advance_out) adv_cnt++;
                tick();
            end
            if ({if_id_valid_out, if_id_instr_out, if_id_pc_out, if_id_pc_nxt_out} !==
                {s_valid, s_instr, s_pc, s_nxt}) held_ok = 1'b0;
            stall_in = 1'b0;
            #4;
            if (pc_advance_out) begin adv_cnt++; adv_in_load = 1'b1; end
            tick();
        end
        stall_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        n_checks++;
        if ({imem_req_out, pc_advance_out, if_id_valid_out, fetch_err_out} !== 4'b0)
            $display("FAIL reset_bits: got %b expected 0000",
                     {imem_req_out, pc_advance_out, if_id_valid_out, fetch_err_out});
        else n_pass++;
        n_checks++;
        if ({imem_addr_out, if_id_pc_out, if_id_pc_nxt_out} !== 96'h0)
            $display("FAIL reset_addr: got %h %h %h expected 0", imem_addr_out, if_id_pc_out, if_id_pc_nxt_out);
        else n_pass++;
        n_checks++;
        if (if_id_instr_out !== NOP)
            $display("FAIL reset_instr: got %h expected %h", if_id_instr_out, NOP);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Scenario checker for a fetch expected to be accepted normally.
    task automatic test_fetch(input string name, input logic [31:0] pc, input int gnt_dly,
                              input int rv_dly, input logic [31:0] data, input int stall_len);
        int rc, ac; bit aok, ail, hok;
        logic [31:0] exp_nxt;
        exp_nxt = pc + 32'd4;
        do_fetch(pc, gnt_dly, rv_dly, data, stall_len, rc, ac, aok, ail, hok);
        n_checks++;
        if (if_id_valid_out !== 1'b1 || if_id_instr_out !== data)
            $display("FAIL %s_instr: got v=%b %h expected v=1 %h", name, if_id_valid_out, if_id_instr_out, data);
        else n_pass++;
        n_checks++;
        if (if_id_pc_out !== pc || if_id_pc_nxt_out !== exp_nxt)
            $display("FAIL %s_pc: got %h/%h expected %h/%h", name, if_id_pc_out, if_id_pc_nxt_out, pc, exp_nxt);
        else n_pass++;
        n_checks++;
        if (ac !== 1 || ail !== 1'b1)
            $display("FAIL %s_advance: got %0d pulses (in load cycle %b) expected 1 (1)", name, ac, ail);
        else n_pass++;
        n_checks++;
        if (rc !== gnt_dly + 1 || aok !== 1'b1)
            $display("FAIL %s_req: got %0d req cycles addr_stable=%b expected %0d, 1", name, rc, aok, gnt_dly + 1);
        else n_pass++;
        if (stall_len > 0) begin
            n_checks++;
            if (hok !== 1'b1) $display("FAIL %s_stall_hold: got IF/ID changed during stall expected retained", name);
            else n_pass++;
        end
    endtask

    task automatic test_flush_wait();
        apply_reset();
        test_fetch("pre_flush", 32'h20, 0, 0, 32'h1234_5678, 0);
        pc_in = 32'h40; tick();                 // IDLE -> REQ
        imem_gnt_in = 1'b1; tick();             // REQ -> WAIT
        imem_gnt_in = 1'b0; flush_in = 1'b1;    // flush, no data yet
        #4;
        n_checks++;
        if (pc_advance_out !== 1'b0) $display("FAIL flush_wait_adv0: got %b expected 0", pc_advance_out);
        else n_pass++;
        tick();
        flush_in = 1'b0;
        n_checks++;
        if (if_id_valid_out !== 1'b0 || if_id_instr_out !== NOP)
            $display("FAIL flush_wait_ifid: got v=%b %h expected v=0 %h", if_id_valid_out, if_id_instr_out, NOP);
        else n_pass++;
        tick();
        imem_rvalid_in = 1'b1; imem_rdata_in = 32'h0BAD_0BAD;
        #4;
        n_checks++;
        if (pc_advance_out !== 1'b0) $display("FAIL flush_wait_drop: got adv=%b expected 0", pc_advance_out);
        else n_pass++;
        tick();
        imem_rvalid_in = 1'b0;
        n_checks++;
        if (if_id_valid_out !== 1'b0 || if_id_instr_out !== NOP)
            $display("FAIL flush_wait_after: got v=%b %h expected v=0 %h", if_id_valid_out, if_id_instr_out, NOP);
        else n_pass++;
        test_fetch("post_flush", 32'h80, 1, 1, 32'hCAFE_F00D, 0);
    endtask

    task automatic test_flush_req();
        apply_reset();
        pc_in = 32'h100; tick();                // IDLE -> REQ
        flush_in = 1'b1; tick();                // flush while requesting
        flush_in = 1'b0; imem_gnt_in = 1'b1; tick();
        imem_gnt_in = 1'b0; imem_rvalid_in = 1'b1; imem_rdata_in = 32'h7777_7777;
        #4;
        n_checks++;
        if (pc_advance_out !== 1'b0) $display("FAIL flush_req_drop: got adv=%b expected 0", pc_advance_out);
        else n_pass++;
        tick();
        imem_rvalid_in = 1'b0;
        n_checks++;
        if (if_id_valid_out !== 1'b0) $display("FAIL flush_req_valid: got %b expected 0", if_id_valid_out);
        else n_pass++;
        test_fetch("post_flush_req", 32'h104, 0, 2, 32'h2222_3333, 0);
    endtask

    task automatic test_flush_stall();
        apply_reset();
        test_fetch("pre_fs", 32'h200, 0, 0, 32'h4444_5555, 0);
        flush_in = 1'b1; stall_in = 1'b1;
        #4;
        n_checks++;
        if (pc_advance_out !== 1'b0) $display("FAIL flush_stall_adv: got %b expected 0", pc_advance_out);
        else n_pass++;
        tick();
        flush_in = 1'b0; stall_in = 1'b0;
        n_checks++;
        if (if_id_valid_out !== 1'b0 || if_id_instr_out !== NOP)
            $display("FAIL flush_stall_ifid: got v=%b %h expected v=0 %h", if_id_valid_out, if_id_instr_out, NOP);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        pc_in = 32'h300; tick();
        imem_gnt_in = 1'b1; tick();              // now in WAIT
        imem_gnt_in = 1'b0;
        rst_n = 1'b0; #2;
        n_checks++;
        if (imem_req_out !== 1'b0 || imem_addr_out !== 32'h0)
            $display("FAIL reset_mid: got req=%b addr=%h expected 0 0", imem_req_out, imem_addr_out);
        else n_pass++;
        tick();
        rst_n = 1'b1;                            // IDLE: late response must be ignored
        imem_rvalid_in = 1'b1; imem_rdata_in = 32'h9999_9999;
        #4;
        n_checks++;
        if (pc_advance_out !== 1'b0) $display("FAIL reset_mid_late_rvalid: got adv=%b expected 0", pc_advance_out);
        else n_pass++;
        tick();
        imem_rvalid_in = 1'b0;
        n_checks++;
        if (if_id_valid_out !== 1'b0) $display("FAIL reset_mid_valid: got %b expected 0", if_id_valid_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        apply_reset();
        for (int t = 0; t < 25; t++) begin
            pc = (t == 3) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            test_fetch("random", pc, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom, $urandom_range(0, 3));
        end
    endtask

    task automatic test_timeout();
        bit exp_err;
        apply_reset();
        tick();                                  // leave IDLE, enter REQ
        for (int i = 0; i < 24; i++) begin
            imem_gnt_in = 1'b0;
            #4;
`ifdef FETCH_TIMEOUT_EN
            exp_err = (i >= 16);
`else
            exp_err = 1'b0;
`endif
            n_checks++;
            if (fetch_err_out !== exp_err || imem_req_out !== 1'b1)
                $display("FAIL timeout_cycle%0d: got err=%b req=%b expected err=%b req=1",
                         i, fetch_err_out, imem_req_out, exp_err);
            else n_pass++;
            tick();
        end
        apply_reset();
        #4;
        n_checks++;
        if (fetch_err_out !== 1'b0) $display("FAIL timeout_reset: got %b expected 0", fetch_err_out);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch("basic", 32'h0, 0, 0, 32'h0050_0093, 0);
        apply_reset();
        test_fetch("gnt_delay", 32'h10, 3, 0, 32'h00A0_0113, 0);
        apply_reset();
        test_fetch("stall", 32'h30, 0, 0, 32'hDEAD_BEEF, 5);
        test_flush_wait();
        test_flush_req();
        test_flush_stall();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
